ctr8_ext_capture: RTL and testbench
===================================

Name: ctr8_ext_capture

Overview:
- Downstream companion to the 8-bit synchronous load/increment counter with carry-out.
- Consumes the counter's q/co/ld to extend it to an (HI_W+8)-bit free-running count.
- Takes coherent snapshots of the extended count on request and queues them in a small FIFO, drained by a valid/ready handshake.
- Sits between the counter and the status/readout logic.

Parameters:
HI_W, 16, width of the extension (high) count; snapshot width is HI_W+8
DEPTH, 4, snapshot FIFO depth; power of two, >= 2

Ports:
clk  in  1  rising-edge clock, shared with the counter
rst_n  in  1  reset, synchronous, active-low
ctr_q  in  8  counter value (registered output of the counter)
ctr_co  in  1  counter carry-out; 1 in the cycle after q wrapped FF->00
ctr_ld  in  1  the load strobe being presented to the counter this cycle
cap_req  in  1  snapshot request, sampled every cycle
cap_valid  out  1  FIFO head holds a snapshot
cap_ready  in  1  consumer accepts the head this cycle
cap_data  out  HI_W+8  snapshot at FIFO head, {hi,lo}
cap_drop  out  1  registered 1-cycle pulse: a request was rejected because the FIFO was full
hi_ovf  out  1  sticky: extension count wrapped
ovf_clr  in  1  clears hi_ovf

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: hi=0, FIFO empty, cap_valid=0, cap_data=0, cap_drop=0, hi_ovf=0.
- Reset has priority over every other input in the same cycle. Reset mid-operation discards queued snapshots.
- Extension register hi[HI_W-1:0], evaluated in priority order at each edge:
  - ctr_ld=1: hi<=0. The counter loads the same edge and clears co; ld beats a coincident ctr_co.
  - else ctr_co=1: hi<=hi+1, modulo 2^HI_W.
  - else hold.
- Wrap: hi all-ones with ctr_co=1 (and no ld): hi<=0 and hi_ovf<=1.
- hi_ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Snapshot value, combinational in the request cycle: {hi + ctr_co, ctr_q}, truncated to HI_W+8.
  - Compensates for hi lagging co by one cycle. Example: hi=0x0003, co=1, q=0x00 gives 0x000400.
  - In an ld cycle the snapshot uses the pre-load values (hi+co, q); the new load value is not visible until the next cycle.
- Push: on cap_req=1, the snapshot is written if count<DEPTH or a pop occurs in the same cycle (full+pop+push accepted). Otherwise it is dropped and cap_drop=1 the next cycle.
- Pop: cap_valid & cap_ready.
  - cap_data/cap_valid are registered from FIFO state.
  - Latency from cap_req on an empty FIFO to cap_valid=1 is 1 cycle.
  - cap_data is stable while cap_valid=1 and cap_ready=0.
- cap_ready while cap_valid=0 is ignored. FIFO order is strict FIFO.
- Empty FIFO with a same-cycle push: no bypass. The data appears the next cycle.

Decomposition:
- Shared package ctr8_pkg holds:
  - CTR_W=8;
  - default HI_W;
  - the typedef for the snapshot word, {hi,lo};
  - the DEPTH default constant.
- One sub-module: cap_fifo, a parameterised synchronous FIFO with registered head output and full/empty/count flags.
- hi/ovf logic stays in the top level.

Test Plan:
- Reset then 300 increments with no ld: co pulses at cycles 256 and later. hi=0x0001 after the first co. cap_req in the co cycle (q=0x00) → cap_data=0x000100.
- ctr_ld=1 in the same cycle as ctr_co=1 with hi=0x0005 → hi=0x0000 next cycle. cap_req in that cycle returns 0x000600 with pre-load q=0x00.
- Force hi=0xFFFF, q=0xFF, then increment → co cycle snapshot 0x000000; hi=0x0000; hi_ovf=1. ovf_clr coincident with a second wrap → hi_ovf stays 1. ovf_clr alone → 0.
- cap_ready=0, issue 5 consecutive cap_req:
  - first 4 are queued; cap_drop pulses once, one cycle after the 5th;
  - cap_data holds the first snapshot;
  - raising cap_ready drains all 4 in order.
- FIFO full, cap_req and cap_ready in the same cycle → accepted, no cap_drop, count stays 4.
- rst_n=0 for one cycle with 3 entries queued and hi=0x0012 → next cycle cap_valid=0, hi=0, hi_ovf=0, cap_drop=0.

Source files
------------

// File: rtl/ctr8_pkg.sv
// Shared constants and types for the 8-bit counter and its extension/capture companion.
package ctr8_pkg;

  localparam int CTR_W     = 8;   // width of the base counter
  localparam int HI_W_DEF  = 16;  // default width of the extension count
  localparam int DEPTH_DEF = 4;   // default snapshot FIFO depth

  // Snapshot word at default widths: extension count above the counter value.
  typedef struct packed {
    logic [HI_W_DEF-1:0] hi;
    logic [CTR_W-1:0]    lo;
  } snap_t;

endpackage

// File: rtl/cap_fifo.sv
// Synchronous FIFO with a registered head word and full/empty flags.
// The head register is loaded with whatever will sit at the read pointer after
// this cycle's push/pop, so dout_o is a pure flop output and holds while idle.
module cap_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          pop, push_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = dout_q;

  // Next pointers, occupancy and head word; a full FIFO still accepts when popping.
  always_comb begin
    pop     = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    dout_d  = dout_q;
    if (count_d != '0) begin
      // The slot becoming head may be the one written this very cycle.
      if (push_ok && (wr_q == rd_d)) dout_d = din_i;
      else                           dout_d = mem_q[rd_d];
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: rtl/ctr8_ext_capture.sv
// Extends the 8-bit counter to HI_W+8 bits using its carry-out and load strobe,
// and queues coherent snapshots of the extended count on request.
module ctr8_ext_capture
  import ctr8_pkg::*;
#(
  parameter int HI_W  = HI_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CTR_W-1:0]      ctr_q,
  input  logic                  ctr_co,
  input  logic                  ctr_ld,
  input  logic                  cap_req,
  output logic                  cap_valid,
  input  logic                  cap_ready,
  output logic [HI_W+CTR_W-1:0] cap_data,
  output logic                  cap_drop,
  output logic                  hi_ovf,
  input  logic                  ovf_clr
);

  localparam int SW = HI_W + CTR_W;

  typedef struct packed {
    logic [HI_W-1:0]  hi;
    logic [CTR_W-1:0] lo;
  } ext_snap_t;

  logic [HI_W-1:0] hi_q, hi_d;
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;
  logic            wrap;
  ext_snap_t       snap;
  logic            fifo_full, fifo_empty;

  // hi lags co by a cycle, so fold the pending carry into the snapshot.
  // During a load the pre-load values are captured; the load shows up next cycle.
  always_comb begin
    snap.hi = hi_q + HI_W'(ctr_co);
    snap.lo = ctr_q;
  end

  // Extension count: load clears, carry increments, wrap sets the sticky flag.
  always_comb begin
    wrap  = ~ctr_ld & ctr_co & (hi_q == '1);
    hi_d  = hi_q;
    ovf_d = ovf_q;
    drop_d = cap_req & fifo_full & ~(cap_ready & ~fifo_empty);
    if (ctr_ld)      hi_d = '0;
    else if (ctr_co) hi_d = hi_q + HI_W'(1);
    if (wrap)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Extension count, overflow flag and drop pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  cap_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap_req),
    .din_i   (snap),
    .pop_i   (cap_ready),
    .dout_o  (cap_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cap_valid = ~fifo_empty;
  assign cap_drop  = drop_q;
  assign hi_ovf    = ovf_q;

endmodule

// File: tb/tb_ctr8_ext_capture.sv
// Randomised and directed bench for ctr8_ext_capture against a queue-based model.
module tb_ctr8_ext_capture;

  localparam int HI_W   = 8;          // narrow extension keeps wrap tests short
  localparam int DEPTH  = 4;
  localparam int SW     = HI_W + 8;
  localparam int HI_MOD = 1 << HI_W;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [7:0]    ctr_q = 0;
  logic          ctr_co = 0, ctr_ld = 0, cap_req = 0, cap_ready = 0, ovf_clr = 0;
  logic          cap_valid, cap_drop, hi_ovf;
  logic [SW-1:0] cap_data;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int            hi_m;
  bit            ovf_m, drop_m;
  logic [SW-1:0] data_m;
  logic [SW-1:0] fq[$];

  ctr8_ext_capture #(.HI_W(HI_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ctr_q(ctr_q), .ctr_co(ctr_co), .ctr_ld(ctr_ld),
    .cap_req(cap_req), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_data(cap_data), .cap_drop(cap_drop), .hi_ovf(hi_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Advance model with the inputs presented this cycle, then clock the DUT.
  task automatic tick();
    logic [SW-1:0] snap;
    bit pop, acc;
    if (!rst_n) begin
      hi_m = 0; ovf_m = 0; drop_m = 0; data_m = '0; fq.delete();
    end else begin
      snap = SW'(((hi_m + int'(ctr_co)) % HI_MOD) * 256 + int'(ctr_q));
      pop = cap_ready && (fq.size() > 0);
      if (pop) void'(fq.pop_front());
      acc = cap_req && (fq.size() < DEPTH);
      if (acc) fq.push_back(snap);
      drop_m = cap_req && !acc;
      if (ctr_ld) hi_m = 0;
      else if (ctr_co) begin
        if (hi_m == HI_MOD - 1) begin hi_m = 0; ovf_m = 1; end
        else begin hi_m++; if (ovf_clr) ovf_m = 0; end
      end else if (ovf_clr) ovf_m = 0;
      if (ctr_ld && ovf_clr) ovf_m = 0;
      if (fq.size() > 0) data_m = fq[0];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ctr_ld = 0; ctr_co = 0; cap_req = 0; cap_ready = 0; ovf_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); cap_req = 1; ctr_co = 1;
    tick(); tick();
    n_checks++;
    if (cap_valid !== 1'b0 || cap_data !== '0 || cap_drop !== 1'b0 || hi_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset: valid=%b data=%h drop=%b ovf=%b, want 0 0 0 0", cap_valid, cap_data, cap_drop, hi_ovf);
    end
    rst_n = 1; idle_inputs(); tick();
  endtask

  // Emulate the real counter for 300 increments; capture in the first co cycle.
  task automatic test_count();
    logic [7:0]    c_q = 0;
    logic          c_co = 0;
    logic [SW-1:0] e;
    rst_n = 0; idle_inputs(); tick(); rst_n = 1;
    cap_ready = 1;
    for (int i = 0; i < 300; i++) begin
      ctr_q = c_q; ctr_co = c_co; cap_req = c_co;
      tick();
      n_checks++;
      if (cap_valid !== 1'(fq.size() > 0) || cap_data !== data_m || cap_drop !== drop_m || hi_ovf !== ovf_m) begin
        n_err++;
        $display("FAIL count cyc %0d: valid=%b data=%h drop=%b ovf=%b, want %b %h %b %b", i, cap_valid, cap_data, cap_drop, hi_ovf, fq.size() > 0, data_m, drop_m, ovf_m);
      end
      if (i == 256) begin
        e = {HI_W'(1), 8'h00};
        n_checks++;
        if (cap_valid !== 1'b1 || cap_data !== e) begin
          n_err++;
          $display("FAIL first_co_snap: valid=%b data=%h, want 1 %h", cap_valid, cap_data, e);
        end
      end
      c_co = (c_q == 8'hFF);
      c_q  = c_q + 8'd1;
    end
    idle_inputs(); cap_ready = 1; tick();
  endtask

  // Load coincident with carry: snapshot uses pre-load values, hi clears.
  task automatic test_ld_co();
    logic [SW-1:0] e;
    idle_inputs(); cap_ready = 1; ctr_ld = 1; tick();
    ctr_ld = 0; ctr_co = 1;
    for (int i = 0; i < 5; i++) begin ctr_q = 8'($urandom); tick(); end
    ctr_ld = 1; ctr_co = 1; ctr_q = 8'h00; cap_req = 1; tick();
    e = {HI_W'(6), 8'h00};
    n_checks++;
    if (cap_valid !== 1'b1 || cap_data !== e || cap_data !== data_m) begin
      n_err++;
      $display("FAIL ld_co_snap: valid=%b data=%h, want 1 %h", cap_valid, cap_data, e);
    end
    ctr_ld = 0; ctr_co = 0; ctr_q = 8'h33; tick();
    e = {HI_W'(0), 8'h33};
    n_checks++;
    if (cap_valid !== 1'b1 || cap_data !== e) begin
      n_err++;
      $display("FAIL ld_cleared_hi: valid=%b data=%h, want 1 %h", cap_valid, cap_data, e);
    end
    idle_inputs(); cap_ready = 1; tick();
  endtask

  // Extension wrap, sticky overflow, set beats clear.
  task automatic test_wrap();
    logic [SW-1:0] e;
    idle_inputs(); cap_ready = 1; ctr_ld = 1; ovf_clr = 1; tick();
    ctr_ld = 0; ovf_clr = 0; ctr_co = 1;
    for (int i = 0; i < HI_MOD - 1; i++) tick();
    ctr_co = 0; ctr_q = 8'hFF; cap_req = 1; tick();
    e = '1;
    n_checks++;
    if (cap_data !== e || hi_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL hi_full: data=%h ovf=%b, want %h 0", cap_data, hi_ovf, e);
    end
    ctr_co = 1; ctr_q = 8'h00; tick();
    e = '0;
    n_checks++;
    if (cap_data !== e || hi_ovf !== 1'b1 || cap_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_snap: data=%h ovf=%b valid=%b, want %h 1 1", cap_data, hi_ovf, cap_valid, e);
    end
    cap_req = 0;
    for (int i = 0; i < HI_MOD - 1; i++) tick();
    ovf_clr = 1; tick();
    n_checks++;
    if (hi_ovf !== 1'b1 || hi_ovf !== ovf_m) begin
      n_err++;
      $display("FAIL ovf_set_beats_clr: ovf=%b, want 1", hi_ovf);
    end
    ctr_co = 0; ovf_clr = 1; ctr_q = 8'h00; cap_req = 1; tick();
    n_checks++;
    if (hi_ovf !== 1'b0 || cap_data !== {HI_W'(0), 8'h00}) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b data=%h, want 0 %h", hi_ovf, cap_data, {HI_W'(0), 8'h00});
    end
    idle_inputs(); cap_ready = 1; tick();
  endtask

  // Fill, overflow by one, full push+pop, then drain in order.
  task automatic test_fifo_full();
    int            drops = 0;
    logic [SW-1:0] first, got[$];
    logic [7:0]    exp_lo [4];
    idle_inputs(); tick();
    first = SW'(hi_m * 256 + 8'h10);
    for (int i = 0; i < 6; i++) begin
      cap_req = (i < 5); ctr_q = 8'(8'h10 + i);
      tick();
      if (cap_drop === 1'b1) drops++;
      n_checks++;
      if (cap_drop !== (i == 4) || cap_valid !== 1'b1 || cap_data !== first) begin
        n_err++;
        $display("FAIL fill %0d: drop=%b valid=%b data=%h, want %b 1 %h", i, cap_drop, cap_valid, cap_data, i == 4, first);
      end
    end
    n_checks++;
    if (drops != 1) begin
      n_err++;
      $display("FAIL drop_count: got %0d drop pulses, want 1", drops);
    end
    cap_req = 1; cap_ready = 1; ctr_q = 8'h55; tick();
    n_checks++;
    if (cap_drop !== 1'b0 || cap_data !== data_m) begin
      n_err++;
      $display("FAIL full_push_pop: drop=%b data=%h, want 0 %h", cap_drop, cap_data, data_m);
    end
    cap_ready = 0; ctr_q = 8'h66; tick();
    n_checks++;
    if (cap_drop !== 1'b1) begin
      n_err++;
      $display("FAIL still_full: drop=%b, want 1", cap_drop);
    end
    cap_req = 0; cap_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (cap_valid === 1'b1) got.push_back(cap_data);
      tick();
    end
    exp_lo[0] = 8'h11; exp_lo[1] = 8'h12; exp_lo[2] = 8'h13; exp_lo[3] = 8'h55;
    n_checks++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL drain_count: got %0d entries, want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== SW'(hi_m * 256 + int'(exp_lo[i]))) begin
        n_err++;
        $display("FAIL drain_order %0d: got %h, want lo %h", i, got[i], exp_lo[i]);
      end
    end
    idle_inputs();
  endtask

  // Reset with entries queued and hi nonzero.
  task automatic test_reset_mid();
    idle_inputs(); ctr_ld = 1; tick(); ctr_ld = 0; ctr_co = 1;
    for (int i = 0; i < 8'h12; i++) tick();
    ctr_co = 0; cap_req = 1;
    for (int i = 0; i < 3; i++) begin ctr_q = 8'(i); tick(); end
    rst_n = 0; ctr_co = 1; tick();
    n_checks++;
    if (cap_valid !== 1'b0 || cap_drop !== 1'b0 || hi_ovf !== 1'b0 || cap_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b drop=%b ovf=%b data=%h, want 0 0 0 0", cap_valid, cap_drop, hi_ovf, cap_data);
    end
    rst_n = 1; ctr_co = 0; ctr_q = 8'h7E; tick();
    n_checks++;
    if (cap_valid !== 1'b1 || cap_data !== {HI_W'(0), 8'h7E}) begin
      n_err++;
      $display("FAIL reset_mid_hi: valid=%b data=%h, want 1 %h", cap_valid, cap_data, {HI_W'(0), 8'h7E});
    end
    idle_inputs(); cap_ready = 1; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(63) != 0);
      ctr_ld    = ($urandom_range(15) == 0);
      ctr_co    = ($urandom_range(1) == 1);
      ctr_q     = 8'($urandom);
      cap_req   = ($urandom_range(1) == 1);
      cap_ready = ($urandom_range(2) == 0);
      ovf_clr   = ($urandom_range(7) == 0);
      tick();
      n_checks++;
      if (cap_valid !== 1'(fq.size() > 0) || cap_data !== data_m || cap_drop !== drop_m || hi_ovf !== ovf_m) begin
        n_err++;
        $display("FAIL rand cyc %0d: valid=%b data=%h drop=%b ovf=%b, want %b %h %b %b", i, cap_valid, cap_data, cap_drop, hi_ovf, fq.size() > 0, data_m, drop_m, ovf_m);
      end
    end
    rst_n = 1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_count();
    test_ld_co();
    test_wrap();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
